measure_sequencer: RTL and testbench
====================================

MEASURE_SEQUENCER -- requirements
Module: measure_sequencer

Interface
REQ-001 Parameter START_WAIT, default 16, meaning: max cycles from meas_start to meas_busy high.
REQ-002 Parameter DONE_WAIT, default 2**24, meaning: max cycles meas_busy may stay high.
REQ-003 Parameter SAT_LIMIT, default 32'h7FFF_FFFF, meaning: channel counts >= this are saturated and ineligible.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  host requests one measurement.
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 meas_start  out  1  start pulse to the parallel-counter measurement block.
REQ-010 meas_busy  in  1  busy from the measurement block.
REQ-011 meas_val  in  NUM_CH x 32  per-channel counts, valid while meas_busy low.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  host accepts result.
REQ-014 res_ch  out  4  selected channel index 0..NUM_CH-1.
REQ-015 res_val  out  32  selected channel count.
REQ-016 res_err  out  2  err_t code.

Function
REQ-017 States: IDLE, START, WAIT_BUSY, WAIT_DONE, SCAN, RESULT; the state register SHALL be one-hot.
REQ-018 IDLE: a cycle with req_valid & req_ready -> START; otherwise hold.
REQ-019 START: meas_start=1 for exactly one cycle, wait counter cleared -> WAIT_BUSY.
REQ-020 WAIT_BUSY: meas_busy=1 -> WAIT_DONE with counter cleared; counter reaching START_WAIT first -> RESULT with res_err=ERR_NOSTART.
REQ-021 WAIT_DONE: meas_busy=0 -> SCAN; counter reaching DONE_WAIT first -> RESULT with res_err=ERR_TIMEOUT.
REQ-022 SCAN: examine one channel per cycle, index 0..NUM_CH-1, exactly NUM_CH cycles, then -> RESULT.
REQ-023 Eligibility: val < SAT_LIMIT and val != 0.
REQ-024 Selection: the eligible channel with the largest val; ties go to the lowest index (strict > compare).
REQ-025 No eligible channel: res_err=ERR_NORANGE, res_ch=0, res_val=0; otherwise ERR_OK.
REQ-026 RESULT: res_valid=1, with res_ch, res_val and res_err stable until res_valid & res_ready; that cycle -> IDLE.
REQ-027 res_ready arriving in the first RESULT cycle SHALL complete the transfer in that cycle.
REQ-028 Error paths SHALL present res_ch=0 and res_val=0.
REQ-029 req_valid outside IDLE SHALL be ignored and not queued.
REQ-030 Latency from accept to meas_start SHALL be 1 cycle.
REQ-031 Latency from meas_busy falling to res_valid SHALL be NUM_CH+1 cycles.
REQ-032 Wait counters SHALL saturate and never wrap; the counter width SHALL be $clog2(max(START_WAIT, DONE_WAIT)+1).

Reset
REQ-033 rst SHALL force IDLE: req_ready=1, meas_start=0, res_valid=0, res_ch=0, res_val=0, res_err=ERR_OK, counters and best-so-far registers=0.
REQ-034 rst asserted in any state SHALL abort the operation on the next edge, and any result in flight SHALL be discarded.
REQ-035 meas_busy SHALL be ignored after reset until START.

Structure
REQ-036 Package meas_pkg SHALL hold NUM_CH=10, VAL_W=32, the state_t enum and err_t {ERR_OK=0, ERR_NOSTART=1, ERR_TIMEOUT=2, ERR_NORANGE=3}.
REQ-037 Sub-module range_select SHALL implement the per-cycle compare/update of the best index and value, with inputs start, step, val and idx and outputs best_idx, best_val and found.
REQ-038 All other logic SHALL be a single FSM plus one saturating wait counter.

Verification
REQ-039 Nominal: request; busy high 3 cycles after meas_start, low after 100; meas_val ch0..9 = 5,50,500,5000,50000,7FFF_FFFF,… -> res_ch=4, res_val=50000, ERR_OK, res_valid 11 cycles after busy falls.
REQ-040 Tie: ch2=ch7=1234, all others 0 -> res_ch=2, res_val=1234.
REQ-041 No range: all channels 0 or >= SAT_LIMIT -> ERR_NORANGE, res_ch=0, res_val=0.
REQ-042 Busy never rises, START_WAIT=16 -> ERR_NOSTART 17 cycles after meas_start; busy stuck high with DONE_WAIT=64 -> ERR_TIMEOUT.
REQ-043 Handshake: res_ready low 5 cycles -> outputs stable and req_ready=0 throughout; a second req_valid during WAIT_DONE is ignored.
REQ-044 rst pulsed during SCAN and during RESULT -> all outputs at reset values next cycle; a new request then completes normally.

Source files
------------

// File: rtl/measure_sequencer_pkg.sv
// Shared types and constants for the measurement sequencer and its range selector.
package meas_pkg;

    localparam int NUM_CH = 10;
    localparam int VAL_W  = 32;
    localparam int IDX_W  = 4;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_START     = 6'b000010,
        S_WAIT_BUSY = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_SCAN      = 6'b010000,
        S_RESULT    = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NOSTART = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_NORANGE = 2'd3
    } err_t;

    // A count is usable only if it is non-zero and below the saturation limit.
    function automatic logic eligible(input logic [VAL_W-1:0] val, input logic [VAL_W-1:0] lim);
        return (val < lim) && (val != '0);
    endfunction

endpackage

// File: rtl/measure_sequencer_range_select.sv
// Running best-channel tracker: one channel is offered per step, the largest eligible count wins.
module range_select
    import meas_pkg::*;
#(
    parameter logic [VAL_W-1:0] SAT_LIMIT = 32'h7FFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [VAL_W-1:0] val,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] best_idx,
    output logic [VAL_W-1:0] best_val,
    output logic             found
);

    logic [IDX_W-1:0] r_best_idx;
    logic [VAL_W-1:0] r_best_val;
    logic             r_found;

    // Strict compare keeps the lowest index on ties; best_val starts at 0 and
    // eligible values are non-zero, so the first eligible channel always wins.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_best_idx <= '0;
            r_best_val <= '0;
            r_found    <= 1'b0;
        end else if (step && eligible(val, SAT_LIMIT) && (val > r_best_val)) begin
            r_best_idx <= idx;
            r_best_val <= val;
            r_found    <= 1'b1;
        end
    end

    assign best_idx = r_best_idx;
    assign best_val = r_best_val;
    assign found    = r_found;

endmodule

// File: rtl/measure_sequencer.sv
// Sequences one measurement: start pulse, wait for busy rise/fall with timeouts,
// scan all channels for the best in-range count, and hold the result until accepted.
module measure_sequencer
    import meas_pkg::*;
#(
    parameter int               START_WAIT = 16,
    parameter int               DONE_WAIT  = 2**24,
    parameter logic [VAL_W-1:0] SAT_LIMIT  = 32'h7FFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    output logic                         meas_start,
    input  logic                         meas_busy,
    input  logic [NUM_CH-1:0][VAL_W-1:0] meas_val,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [IDX_W-1:0]             res_ch,
    output logic [VAL_W-1:0]             res_val,
    output logic [1:0]                   res_err
);

    localparam int CNT_MAX = (START_WAIT > DONE_WAIT) ? START_WAIT : DONE_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_WAIT - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(NUM_CH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    err_t             r_err;

    logic             w_accept;
    logic             w_busy_rise;
    logic             w_nostart;
    logic             w_busy_fall;
    logic             w_timeout;
    logic             w_scan_last;
    logic             w_res_done;

    logic [IDX_W-1:0] w_idx;
    logic [VAL_W-1:0] w_val;
    logic [IDX_W-1:0] w_best_idx;
    logic [VAL_W-1:0] w_best_val;
    logic             w_found;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_busy_rise = (r_state == S_WAIT_BUSY) && meas_busy;
    assign w_nostart   = (r_state == S_WAIT_BUSY) && !meas_busy && (r_cnt >= START_LAST);
    assign w_busy_fall = (r_state == S_WAIT_DONE) && !meas_busy;
    assign w_timeout   = (r_state == S_WAIT_DONE) && meas_busy && (r_cnt >= DONE_LAST);
    assign w_scan_last = (r_state == S_SCAN) && (r_cnt == SCAN_LAST);
    assign w_res_done  = (r_state == S_RESULT) && res_ready;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_accept)    w_next = S_START;
            S_START:                      w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (w_busy_rise) w_next = S_WAIT_DONE;
                         else if (w_nostart) w_next = S_RESULT;
            S_WAIT_DONE: if (w_busy_fall) w_next = S_SCAN;
                         else if (w_timeout) w_next = S_RESULT;
            S_SCAN:      if (w_scan_last) w_next = S_RESULT;
            S_RESULT:    if (w_res_done)  w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // One counter serves both wait phases and doubles as the scan channel index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_START) || w_busy_rise || w_busy_fall) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE) || (r_state == S_SCAN)) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_START)) begin
            r_err <= ERR_OK;
        end else if (w_nostart) begin
            r_err <= ERR_NOSTART;
        end else if (w_timeout) begin
            r_err <= ERR_TIMEOUT;
        end
    end

    assign w_idx = r_cnt[IDX_W-1:0];

    always_comb begin
        w_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == IDX_W'(i)) w_val = meas_val[i];
        end
    end

    range_select #(
        .SAT_LIMIT (SAT_LIMIT)
    ) u_range_select (
        .clk      (clk),
        .rst      (rst),
        .start    (r_state == S_START),
        .step     (r_state == S_SCAN),
        .val      (w_val),
        .idx      (w_idx),
        .best_idx (w_best_idx),
        .best_val (w_best_val),
        .found    (w_found)
    );

    always_comb begin
        req_ready  = 1'b0;
        meas_start = 1'b0;
        res_valid  = 1'b0;
        res_ch     = '0;
        res_val    = '0;
        res_err    = ERR_OK;
        unique case (r_state)
            S_IDLE:  req_ready  = 1'b1;
            S_START: meas_start = 1'b1;
            S_RESULT: begin
                res_valid = 1'b1;
                if (r_err != ERR_OK) begin
                    res_err = r_err;
                end else if (!w_found) begin
                    res_err = ERR_NORANGE;
                end else begin
                    res_ch  = w_best_idx;
                    res_val = w_best_val;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer: nominal, tie, range edges, timeouts, handshake and reset abort.
module tb_measure_sequencer;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid, meas_busy, res_ready;
    logic [9:0][31:0]    meas_val;
    logic                req_ready, meas_start, res_valid;
    logic [3:0]          res_ch;
    logic [31:0]         res_val;
    logic [1:0]          res_err;

    logic                t_req_valid, t_meas_busy, t_res_ready;
    logic                t_req_ready, t_meas_start, t_res_valid;
    logic [3:0]          t_res_ch;
    logic [31:0]         t_res_val;
    logic [1:0]          t_res_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    measure_sequencer u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .meas_start(meas_start), .meas_busy(meas_busy), .meas_val(meas_val),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_val(res_val), .res_err(res_err)
    );

    measure_sequencer #(.DONE_WAIT(64)) u_to (
        .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .meas_start(t_meas_start), .meas_busy(t_meas_busy), .meas_val(meas_val),
        .res_valid(t_res_valid), .res_ready(t_res_ready), .res_ch(t_res_ch),
        .res_val(t_res_val), .res_err(t_res_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request, busy high from 3 cycles after meas_start for busy_len cycles, then wait for res_valid.
    // lat is cycles from busy falling to res_valid (-1 on expiry); st_ok says meas_start was a 1-cycle pulse.
    task automatic run_to_result(input int busy_len, output int lat, output bit st_ok);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        st_ok = meas_start;
        tick();
        st_ok = st_ok && !meas_start;
        tick();
        tick();
        meas_busy = 1'b1;
        repeat (busy_len) tick();
        meas_busy = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (res_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
        checks++; if (meas_start !== 1'b0) begin errors++; $display("FAIL rst_meas_start got=%0b exp=0", meas_start); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
        checks++; if ({res_ch, res_val, res_err} !== 38'd0) begin errors++; $display("FAIL rst_res_fields got=%0d/%0h/%0d exp=0/0/0", res_ch, res_val, res_err); end
        checks++; if (t_req_ready !== 1'b1 || t_res_valid !== 1'b0) begin errors++; $display("FAIL rst_to_inst got=%0b/%0b exp=1/0", t_req_ready, t_res_valid); end
        rst = 1'b0;
        meas_busy = 1'b1;
        repeat (4) tick();
        checks++; if (req_ready !== 1'b1 || meas_start !== 1'b0) begin errors++; $display("FAIL busy_ignored_idle got=%0b/%0b exp=1/0", req_ready, meas_start); end
        meas_busy = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int lat;
        bit st_ok;
        meas_val = '0;
        meas_val[0] = 32'd5;       meas_val[1] = 32'd50;      meas_val[2] = 32'd500;
        meas_val[3] = 32'd5000;    meas_val[4] = 32'd50000;   meas_val[5] = 32'h7FFF_FFFF;
        meas_val[6] = 32'hFFFF_FFFF; meas_val[7] = 32'd0;     meas_val[8] = 32'd40000;
        meas_val[9] = 32'd50000;
        run_to_result(100, lat, st_ok);
        checks++; if (st_ok !== 1'b1) begin errors++; $display("FAIL nom_start_pulse got=%0b exp=1", st_ok); end
        checks++; if (lat != 11) begin errors++; $display("FAIL nom_latency got=%0d exp=11", lat); end
        checks++; if (res_ch !== 4'd4) begin errors++; $display("FAIL nom_ch got=%0d exp=4", res_ch); end
        checks++; if (res_val !== 32'd50000) begin errors++; $display("FAIL nom_val got=%0d exp=50000", res_val); end
        checks++; if (res_err !== 2'd0) begin errors++; $display("FAIL nom_err got=%0d exp=0", res_err); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL nom_first_cycle_accept got=%0b/%0b exp=0/1", res_valid, req_ready); end
    endtask

    task automatic test_tie();
        int lat;
        bit st_ok;
        meas_val = '0;
        meas_val[2] = 32'd1234;
        meas_val[7] = 32'd1234;
        run_to_result(5, lat, st_ok);
        checks++; if (res_ch !== 4'd2 || res_val !== 32'd1234) begin errors++; $display("FAIL tie_sel got=%0d/%0d exp=2/1234", res_ch, res_val); end
        checks++; if (res_err !== 2'd0) begin errors++; $display("FAIL tie_err got=%0d exp=0", res_err); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_range_edges();
        int lat;
        bit st_ok;
        meas_val = '0;
        meas_val[1] = 32'h7FFF_FFFF;
        meas_val[4] = 32'h8000_0000;
        meas_val[8] = 32'hFFFF_FFFF;
        run_to_result(5, lat, st_ok);
        checks++; if (res_err !== 2'd3) begin errors++; $display("FAIL norange_err got=%0d exp=3", res_err); end
        checks++; if (res_ch !== 4'd0 || res_val !== 32'd0) begin errors++; $display("FAIL norange_fields got=%0d/%0h exp=0/0", res_ch, res_val); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        meas_val[3] = 32'h7FFF_FFFE;
        meas_val[9] = 32'd1;
        run_to_result(5, lat, st_ok);
        checks++; if (res_ch !== 4'd3 || res_val !== 32'h7FFF_FFFE || res_err !== 2'd0) begin errors++; $display("FAIL below_limit got=%0d/%0h/%0d exp=3/7ffffffe/0", res_ch, res_val, res_err); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_nostart();
        int lat = -1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL nostart_latency got=%0d exp=17", lat); end
        checks++; if (res_err !== 2'd1 || res_ch !== 4'd0 || res_val !== 32'd0) begin errors++; $display("FAIL nostart_fields got=%0d/%0d/%0h exp=1/0/0", res_err, res_ch, res_val); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat = -1;
        t_req_valid = 1'b1;
        tick();
        t_req_valid = 1'b0;
        t_meas_busy = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (t_res_valid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 66) begin errors++; $display("FAIL timeout_latency got=%0d exp=66", lat); end
        checks++; if (t_res_err !== 2'd2 || t_res_ch !== 4'd0 || t_res_val !== 32'd0) begin errors++; $display("FAIL timeout_fields got=%0d/%0d/%0h exp=2/0/0", t_res_err, t_res_ch, t_res_val); end
        t_meas_busy = 1'b0;
        t_res_ready = 1'b1;
        tick();
        t_res_ready = 1'b0;
        checks++; if (t_res_valid !== 1'b0 || t_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_release got=%0b/%0b exp=0/1", t_res_valid, t_req_ready); end
    endtask

    task automatic test_handshake();
        int lat = -1;
        int bad = 0;
        meas_val = '0;
        meas_val[6] = 32'd777;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        meas_busy = 1'b1;
        repeat (3) tick();
        req_valid = 1'b1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_busy got=%0b exp=0", req_ready); end
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        meas_busy = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 11) begin errors++; $display("FAIL hs_latency got=%0d exp=11", lat); end
        for (int k = 0; k < 5; k++) begin
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_ch !== 4'd6 || res_val !== 32'd777 || res_err !== 2'd0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hs_hold_stable got=%0d bad cycles exp=0", bad); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (req_ready !== 1'b1 || meas_start !== 1'b0 || res_valid !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hs_not_queued got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit st_ok;
        meas_val = '0;
        meas_val[5] = 32'd99;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        meas_busy = 1'b1;
        repeat (4) tick();
        meas_busy = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || meas_start !== 1'b0 || res_valid !== 1'b0 || {res_ch, res_val, res_err} !== 38'd0) begin errors++; $display("FAIL rst_scan got=%0b/%0b/%0b/%0d/%0h/%0d exp=1/0/0/0/0/0", req_ready, meas_start, res_valid, res_ch, res_val, res_err); end
        run_to_result(5, lat, st_ok);
        checks++; if (res_valid !== 1'b1 || res_ch !== 4'd5) begin errors++; $display("FAIL rst_pre_result got=%0b/%0d exp=1/5", res_valid, res_ch); end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || {res_ch, res_val, res_err} !== 38'd0) begin errors++; $display("FAIL rst_result got=%0b/%0b/%0d/%0h/%0d exp=1/0/0/0/0", req_ready, res_valid, res_ch, res_val, res_err); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_discard got=%0b exp=0", res_valid); end
        meas_val[8] = 32'd4242;
        run_to_result(20, lat, st_ok);
        checks++; if (lat != 11 || res_ch !== 4'd8 || res_val !== 32'd4242 || res_err !== 2'd0) begin errors++; $display("FAIL rst_recover got=%0d/%0d/%0d/%0d exp=11/8/4242/0", lat, res_ch, res_val, res_err); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        meas_busy = 1'b0;
        res_ready = 1'b0;
        meas_val = '0;
        t_req_valid = 1'b0;
        t_meas_busy = 1'b0;
        t_res_ready = 1'b0;
        test_reset();
        test_nominal();
        test_tie();
        test_range_edges();
        test_nostart();
        test_timeout();
        test_handshake();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
